serial_run_length_encoder: RTL and testbench
============================================

Name: serial_run_length_encoder

Overview:
- Downstream stage of the serial token doubler. Consumes a serial token bit stream and compresses it into run-length records {bit value, run length}.
- Records are buffered in a small FIFO and delivered through a valid/ready interface to a parallel consumer.
- Sticky overflow flags any record lost to back-pressure.

Parameters:
LEN_W, 8, width of run-length field; max run MAX_RUN = 2**LEN_W - 1
FIFO_DEPTH, 4, record FIFO entries; power of two, >= 2

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
in_valid  input  1  in_bit is a stream bit this cycle
in_bit  input  1  serial token bit
flush  input  1  close current run (honoured only when in_valid=0)
out_valid  output  1  record available at FIFO head
out_ready  input  1  consumer accepts head record
out_bit  output  1  bit value of head record
out_len  output  LEN_W  run length of head record, 1..MAX_RUN
fifo_level  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy
overflow  output  1  sticky: a record was dropped

Behaviour:
- Reset values:
  - run_active=0, run_bit=0, run_len=0.
  - FIFO empty: out_valid=0, out_bit=0, out_len=0, fifo_level=0.
  - overflow=0.
- Reset mid-run discards the partial run and all FIFO contents, with no record emitted.
- Run tracker, evaluated on each cycle with in_valid=1:
  - !run_active: run_active=1, run_bit=in_bit, run_len=1; no push.
  - in_bit==run_bit and run_len<MAX_RUN: run_len+1; no push.
  - in_bit==run_bit and run_len==MAX_RUN: push {run_bit, MAX_RUN}; run_len=1 (same bit continues as new run).
  - in_bit!=run_bit: push {run_bit, run_len}; run_bit=in_bit, run_len=1.
- in_valid=0 and flush=1:
  - If run_active: push {run_bit, run_len}; run_active=0, run_len=0.
  - Otherwise no action.
- in_valid=1 and flush=1: flush ignored; bit processed normally.
- Cycles with in_valid=0 and flush=0 hold state; gaps do not split runs.
- At most one push per cycle by construction.
- A record of length 0 is never pushed.
- Length arithmetic is unsigned LEN_W bits; never wraps, saturation handled by the split rule.
- FIFO:
  - Push occurs in the cycle that closes a run.
  - Record visible at the output the next cycle: out_valid latency 1; no combinational bypass.
  - Pop on out_valid && out_ready.
  - out_bit/out_len are driven from the head entry and stay stable while out_valid && !out_ready.
  - Push while full with a pop in the same cycle: both succeed, level unchanged, no overflow.
  - Push while full without a pop: record dropped, overflow<=1 next cycle, FIFO unchanged.
  - Pop while empty is impossible; out_ready ignored when out_valid=0.
  - fifo_level updates registered: +1 push, -1 pop, unchanged on both.
- overflow:
  - Sticky; cleared only by rst.
  - Block keeps encoding and delivering after overflow.

Decomposition:
- Package run_length_pkg:
  - localparam LEN_W default.
  - typedef struct packed {logic bit_val; logic [LEN_W-1:0] len;} rle_rec_t.
  - Function max_run(LEN_W).
- Sub-module rle_fifo:
  - Synchronous FIFO of rle_rec_t with push/pop, full/empty, level, and simultaneous push+pop when full.
  - Top holds the run tracker and overflow logic.

Test Plan:
1. out_ready=1; bits 1,1,0,1,1,1,1,0 then flush -> records (1,2),(0,1),(1,4),(0,1) in order; first out_valid exactly 1 cycle after the cycle carrying the third bit; overflow=0.
2. LEN_W=3 (MAX_RUN=7); 10 consecutive 1s then flush -> (1,7) then (1,3); no length-0 record.
3. Doubler-style stream 1,1,0,1,1,1,1,1,1,0,0 with in_valid gaps of 1-3 cycles between bits, then flush -> (1,2),(0,1),(1,6),(0,2); gaps cause no splits.
4. out_ready=0; bits 0,1,0,1,0,1 then flush (6 pushes, FIFO_DEPTH=4) -> fifo_level=4; overflow rises the cycle after the 5th push and stays 1. Draining yields only (0,1),(1,1),(0,1),(1,1).
5. FIFO full, out_ready=1 in the same cycle a run closes -> push accepted, fifo_level stays 4, overflow stays 0. Also flush together with in_valid=1 -> flush ignored, run continues.
6. Run of five 1s in progress, FIFO holding 2 records, overflow=1; assert rst 1 cycle; then 0,0, flush -> all outputs at reset values after rst; only record (0,2) emitted; overflow=0.

Source files
------------

// File: rtl/serial_run_length_encoder_pkg.sv
// run_length_pkg: types and helpers shared by the serial run-length encoder.
//   LEN_W     - default width of the run-length field
//   rle_rec_t - one run-length record {bit value, run length}
//   max_run() - longest run a LEN_W-bit length field can hold
package run_length_pkg;

  localparam int LEN_W = 8;

  typedef struct packed {
    logic             bit_val;
    logic [LEN_W-1:0] len;
  } rle_rec_t;

  function automatic int max_run(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/serial_run_length_encoder_fifo.sv
// rle_fifo: synchronous FIFO for run-length records.
//   clk, rst        - clock, synchronous active-high reset
//   push, push_data - write request and record
//   pop             - read request (ignored while empty)
//   pop_data        - head record, zero while empty
//   full, empty     - occupancy flags
//   level           - number of stored records
// A push while full is accepted only when a pop happens in the same cycle.
module rle_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (level == DEPTH_LVL);
  assign empty    = (level == '0);
  assign pop_ok   = pop && !empty;
  // When full, the slot at wr_ptr is the head being popped this cycle, so
  // overwriting it is safe: the outgoing value was already read this cycle.
  assign push_ok  = push && (!full || pop_ok);
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/serial_run_length_encoder.sv
// serial_run_length_encoder: compresses a serial bit stream into run-length
// records and delivers them over a valid/ready interface via a small FIFO.
//   clk, rst            - clock, synchronous active-high reset
//   in_valid, in_bit    - serial stream bit
//   flush               - close the current run (only when in_valid=0)
//   out_valid/out_ready - record handshake
//   out_bit, out_len    - head record
//   fifo_level          - FIFO occupancy
//   overflow            - sticky: a record was dropped because the FIFO was full
module serial_run_length_encoder #(
  parameter int LEN_W      = run_length_pkg::LEN_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic                          in_bit,
  input  logic                          flush,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_bit,
  output logic [LEN_W-1:0]              out_len,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);

  import run_length_pkg::*;

  localparam logic [LEN_W-1:0] MAX_RUN = LEN_W'(max_run(LEN_W));

  logic             run_active;
  logic             run_bit;
  logic [LEN_W-1:0] run_len;
  logic             push;
  logic [LEN_W:0]   push_rec;
  logic [LEN_W:0]   head_rec;
  logic             full;
  logic             empty;
  logic             pop;

  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  assign out_bit   = head_rec[LEN_W];
  assign out_len   = head_rec[LEN_W-1:0];

  // A run closes when the bit changes, when it reaches MAX_RUN and the same
  // bit arrives again, or on a flush during an idle cycle.
  always_comb begin
    push     = 1'b0;
    push_rec = {run_bit, run_len};
    if (in_valid) begin
      if (run_active && ((in_bit != run_bit) || (run_len == MAX_RUN))) begin
        push = 1'b1;
      end
    end else if (flush && run_active) begin
      push = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_active <= 1'b0;
      run_bit    <= 1'b0;
      run_len    <= '0;
    end else if (in_valid) begin
      if (!run_active) begin
        run_active <= 1'b1;
        run_bit    <= in_bit;
        run_len    <= LEN_W'(1);
      end else if ((in_bit == run_bit) && (run_len != MAX_RUN)) begin
        run_len <= run_len + 1'b1;
      end else begin
        run_bit <= in_bit;
        run_len <= LEN_W'(1);
      end
    end else if (flush && run_active) begin
      run_active <= 1'b0;
      run_len    <= '0;
    end
  end

  // A record is lost only when the FIFO is full and nothing leaves this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (push && full && !pop) begin
      overflow <= 1'b1;
    end
  end

  rle_fifo #(
    .WIDTH (LEN_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_rec),
    .pop       (pop),
    .pop_data  (head_rec),
    .full      (full),
    .empty     (empty),
    .level     (fifo_level)
  );

endmodule

// File: tb/tb_serial_run_length_encoder.sv
// tb_serial_run_length_encoder: scoreboard bench for serial_run_length_encoder
// (LEN_W=3 so MAX_RUN=7, FIFO_DEPTH=4). Expected records are queued as the
// stimulus is issued; a monitor pops and compares on each accepted record.
module tb_serial_run_length_encoder;

  localparam int LEN_W      = 3;
  localparam int FIFO_DEPTH = 4;

  logic                        clk = 1'b0;
  logic                        rst = 1'b1;
  logic                        in_valid = 1'b0;
  logic                        in_bit = 1'b0;
  logic                        flush = 1'b0;
  logic                        out_ready = 1'b0;
  logic                        out_valid;
  logic                        out_bit;
  logic [LEN_W-1:0]            out_len;
  logic [$clog2(FIFO_DEPTH):0] fifo_level;
  logic                        overflow;

  typedef struct {
    int b;
    int len;
  } rec_t;

  rec_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  serial_run_length_encoder #(
    .LEN_W      (LEN_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_bit     (in_bit),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_bit    (out_bit),
    .out_len    (out_len),
    .fifo_level (fifo_level),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // One cycle of stimulus, applied just after a rising edge.
  task automatic applyStimulus(input logic v, input logic b, input logic f, input logic r);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_bit    = b;
    flush     = f;
    out_ready = r;
  endtask

  task automatic expectRec(input int b, input int len);
    rec_t e;
    e.b   = b;
    e.len = len;
    exp_q.push_back(e);
  endtask

  task automatic sendBit(input logic b, input logic r);
    applyStimulus(1'b1, b, 1'b0, r);
  endtask

  task automatic applyReset();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_out_valid"}, int'(out_valid), 0);
    checkOutput({tag, "_out_bit"}, int'(out_bit), 0);
    checkOutput({tag, "_out_len"}, int'(out_len), 0);
    checkOutput({tag, "_fifo_level"}, int'(fifo_level), 0);
    checkOutput({tag, "_overflow"}, int'(overflow), 0);
  endtask

  // Drain with out_ready=1 until every expected record has been seen.
  task automatic waitDrain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      n++;
    end
    checkOutput({tag, "_drain_pending"}, exp_q.size(), 0);
    exp_q.delete();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput({tag, "_no_extra_record"}, int'(out_valid), 0);
  endtask

  // Monitor: a record is consumed at the edge following a negedge where
  // out_valid && out_ready hold.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_record: got (%0d,%0d) expected none at %0t",
                 out_bit, out_len, $time);
      end else begin
        rec_t e;
        e = exp_q.pop_front();
        checkOutput("rec_bit", int'(out_bit), e.b);
        checkOutput("rec_len", int'(out_len), e.len);
      end
    end
  end

  initial begin
    int gaps [11];
    logic sbits [11];

    applyReset();
    checkReset("reset");

    // Test 1: basic runs and output latency.
    $display("[TB] test 1: basic encoding");
    expectRec(1, 2); expectRec(0, 1); expectRec(1, 4); expectRec(0, 1);
    sendBit(1'b1, 1'b1);
    sendBit(1'b1, 1'b1);
    sendBit(1'b0, 1'b1);
    checkOutput("t1_valid_before_push", int'(out_valid), 0);
    sendBit(1'b1, 1'b1);
    checkOutput("t1_valid_latency", int'(out_valid), 1);
    sendBit(1'b1, 1'b1);
    sendBit(1'b1, 1'b1);
    sendBit(1'b1, 1'b1);
    sendBit(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    waitDrain("t1");
    checkOutput("t1_overflow", int'(overflow), 0);

    // Test 2: saturation split at MAX_RUN=7.
    $display("[TB] test 2: max run split");
    expectRec(1, 7); expectRec(1, 3);
    for (int i = 0; i < 10; i++) sendBit(1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    waitDrain("t2");

    // Test 3: gaps between bits never split runs.
    $display("[TB] test 3: gapped stream");
    sbits = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    gaps  = '{1, 3, 2, 1, 2, 3, 1, 2, 3, 1, 2};
    expectRec(1, 2); expectRec(0, 1); expectRec(1, 6); expectRec(0, 2);
    for (int i = 0; i < 11; i++) begin
      sendBit(sbits[i], 1'b1);
      for (int g = 0; g < gaps[i]; g++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    waitDrain("t3");

    // Test 4: back-pressure overflow.
    $display("[TB] test 4: overflow");
    sendBit(1'b0, 1'b0);
    sendBit(1'b1, 1'b0);
    sendBit(1'b0, 1'b0);
    sendBit(1'b1, 1'b0);
    sendBit(1'b0, 1'b0);
    sendBit(1'b1, 1'b0);
    checkOutput("t4_overflow_before_5th", int'(overflow), 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("t4_overflow_after_5th", int'(overflow), 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("t4_level_full", int'(fifo_level), 4);
    checkOutput("t4_overflow_sticky", int'(overflow), 1);
    expectRec(0, 1); expectRec(1, 1); expectRec(0, 1); expectRec(1, 1);
    waitDrain("t4");
    checkOutput("t4_overflow_after_drain", int'(overflow), 1);

    // Test 5: push with pop while full; flush ignored with in_valid=1.
    $display("[TB] test 5: full push+pop and flush with valid");
    applyReset();
    checkOutput("t5_overflow_reset", int'(overflow), 0);
    sendBit(1'b0, 1'b0);
    sendBit(1'b1, 1'b0);
    sendBit(1'b0, 1'b0);
    sendBit(1'b1, 1'b0);
    sendBit(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("t5_level_full", int'(fifo_level), 4);
    expectRec(0, 1); expectRec(1, 1); expectRec(0, 1); expectRec(1, 1); expectRec(0, 1);
    sendBit(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("t5_level_push_pop", int'(fifo_level), 4);
    checkOutput("t5_overflow_push_pop", int'(overflow), 0);
    expectRec(1, 2); expectRec(0, 1);
    sendBit(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    waitDrain("t5");
    checkOutput("t5_overflow_end", int'(overflow), 0);

    // Test 6: reset mid-run discards run and FIFO.
    $display("[TB] test 6: reset mid-run");
    sendBit(1'b0, 1'b0);
    sendBit(1'b1, 1'b0);
    sendBit(1'b0, 1'b0);
    sendBit(1'b1, 1'b0);
    sendBit(1'b0, 1'b0);
    sendBit(1'b1, 1'b0);
    expectRec(0, 1); expectRec(1, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) sendBit(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("t6_level_before_rst", int'(fifo_level), 2);
    checkOutput("t6_overflow_before_rst", int'(overflow), 1);
    checkOutput("t6_scoreboard_before_rst", exp_q.size(), 0);
    applyReset();
    checkReset("t6_after_rst");
    expectRec(0, 2);
    sendBit(1'b0, 1'b1);
    sendBit(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    waitDrain("t6");
    checkOutput("t6_overflow_end", int'(overflow), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
